// File: rtl/keypad_event_fifo.sv
// Keypad event FIFO: buffers scanner key codes for the consumer, first-word-fall-through, sticky overflow.
// Optional build macro KEYPAD_EVENT_FIFO_DUP_FILTER_EN enables one-event-per-press release filtering.
module keypad_event_fifo #(
   parameter int COL_W = 4,
   parameter int ROW_W = 4,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       listo,
   input  logic [COL_W-1:0]           col,
   input  logic [ROW_W-1:0]           row,
   input  logic                       rd_en,
   input  logic                       ovf_clr,
   output logic [COL_W-1:0]           colM,
   output logic [ROW_W-1:0]           rowM,
   output logic                       validM,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = COL_W + ROW_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0] count_q, count_next;
   logic [EW-1:0] head_q, head_next;
   logic          valid_q, full_q, ovf_q;
   logic          capture, push_try, push, pop, drop;

   assign capture = listo && (col != {COL_W{1'b1}});

`ifdef KEYPAD_EVENT_FIFO_DUP_FILTER_EN
   logic armed_q;

   // A held key only counts once; any non-capture cycle re-arms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         armed_q <= 1'b1;
      else
         armed_q <= !capture;
   end

   assign push_try = capture && armed_q;
`else
   assign push_try = capture;
`endif

   assign pop  = rd_en && valid_q;
   assign push = push_try && (!full_q || pop);
   assign drop = push_try && full_q && !pop;

   always_comb begin
      count_next = count_q;
      rd_next    = rd_ptr;
      head_next  = head_q;
      if (push && !pop)
         count_next = count_q + CW'(1);
      else if (pop && !push)
         count_next = count_q - CW'(1);
      if (pop)
         rd_next = rd_ptr + PW'(1);
      // The new head may be the entry being written this very cycle.
      if (count_next != '0) begin
         if (push && (wr_ptr == rd_next))
            head_next = {col, row};
         else
            head_next = mem[rd_next];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {col, row};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         rd_ptr  <= rd_next;
         count_q <= count_next;
         head_q  <= head_next;
         valid_q <= (count_next != '0);
         full_q  <= (count_next == DEPTH_C);
         // Setting on a drop takes priority over a clear in the same cycle.
         if (drop)
            ovf_q <= 1'b1;
         else if (ovf_clr)
            ovf_q <= 1'b0;
      end
   end

   assign colM     = head_q[EW-1:ROW_W];
   assign rowM     = head_q[ROW_W-1:0];
   assign validM   = valid_q;
   assign full     = full_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule
